// File: rtl/discharge_pkg.sv
// Shared types and helpers for the EDM discharge pulse sequencer.
package discharge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BLANK,
    WAIT_BD,
    DISCHARGE,
    OFF
  } state_t;

  // One-hot so it can drive the statistics counters directly.
  typedef enum logic [2:0] {
    C_NONE   = 3'b000,
    C_NULL   = 3'b001,
    C_NORMAL = 3'b010,
    C_SHORT  = 3'b100
  } cls_t;

  function automatic logic [7:0] leg_mask(input logic [3:0] ip);
    logic [3:0] n;
    logic [8:0] m;
    if (ip == 4'd0) n = 4'd1;
    else if (ip > 4'd8) n = 4'd8;
    else n = ip;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

  function automatic logic [15:0] at_least_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/discharge_pulse_ctrl_cnt.sv
// Saturating null/normal/short pulse counters with a clear strobe.
module pulse_stat_cnt
  import discharge_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [2:0] hit,
  output logic [7:0] null_num,
  output logic [7:0] normal_num,
  output logic [7:0] short_num
);

  function automatic logic [7:0] sat_inc(
    input logic [7:0] c,
    input logic       en
  );
    return (en && c != 8'hFF) ? c + 8'd1 : c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      null_num   <= 8'd0;
      normal_num <= 8'd0;
      short_num  <= 8'd0;
    end else begin
      null_num   <= sat_inc(null_num, hit[0]);
      normal_num <= sat_inc(normal_num, hit[1]);
      short_num  <= sat_inc(short_num, hit[2]);
    end
  end

endmodule

// File: rtl/discharge_pulse_ctrl.sv
// EDM discharge pulse sequencer: gate-on, breakdown wait, Ton, Toff,
// and per-pulse null/normal/short classification.
module discharge_pulse_ctrl
  import discharge_pkg::*;
#(
  parameter int          TICK_DIV    = 10,
  parameter logic [15:0] V_BREAK_TH  = 16'd1200,
  parameter logic [15:0] V_SHORT_TH  = 16'd300,
  parameter int          BLANK_TICKS = 4,
  parameter logic [15:0] MAX_WAIT    = 16'd2000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        is_machine,
  input  logic [15:0] Ton_data,
  input  logic [15:0] Toff_data,
  input  logic [15:0] Ip_data,
  input  logic [15:0] sample_voltage,
  input  logic        cnt_clr,
  output logic [7:0]  pwm,
  output logic [1:0]  pwm_q,
  output logic        pulse_start,
  output logic        pulse_done,
  output logic [7:0]  null_pulse_num,
  output logic [7:0]  normal_pulse_num,
  output logic [7:0]  short_pulse_num
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre;
  logic          tick;
  logic          expired;
  state_t        state;
  state_t        state_n;
  logic [15:0]   tmr;
  logic [15:0]   tmr_n;
  logic [15:0]   ton_q;
  logic [15:0]   toff_q;
  logic [7:0]    mask_q;
  logic [7:0]    mask_n;
  logic          load;
  logic          on_n;
  logic          unused_ip;
  cls_t          cls;

  assign tick      = (pre == PW'(TICK_DIV - 1));
  assign expired   = tick && (tmr <= 16'd1);
  assign unused_ip = ^Ip_data[15:4];
  assign mask_n    = load ? leg_mask(Ip_data[3:0]) : mask_q;
  assign on_n      = (state_n == BLANK) ||
                     (state_n == WAIT_BD) ||
                     (state_n == DISCHARGE);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) pre <= '0;
    else if (tick) pre <= '0;
    else pre <= pre + PW'(1);
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    cls     = C_NONE;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_machine) begin
          state_n = BLANK;
          load    = 1'b1;
          tmr_n   = 16'(BLANK_TICKS);
        end
      end
      BLANK: begin
        if (!is_machine) begin
          state_n = IDLE;
        end else if (expired) begin
          state_n = WAIT_BD;
          tmr_n   = MAX_WAIT;
        end else if (tick) begin
          tmr_n = tmr - 16'd1;
        end
      end
      WAIT_BD: begin
        if (!is_machine) begin
          state_n = IDLE;
        end else if (sample_voltage < V_SHORT_TH) begin
          state_n = OFF;
          cls     = C_SHORT;
          tmr_n   = toff_q;
        end else if (sample_voltage < V_BREAK_TH) begin
          state_n = DISCHARGE;
          tmr_n   = ton_q;
        end else if (expired) begin
          state_n = OFF;
          cls     = C_NULL;
          tmr_n   = toff_q;
        end else if (tick) begin
          tmr_n = tmr - 16'd1;
        end
      end
      DISCHARGE: begin
        if (!is_machine) begin
          state_n = IDLE;
        end else if (expired) begin
          state_n = OFF;
          cls     = C_NORMAL;
          tmr_n   = toff_q;
        end else if (tick) begin
          tmr_n = tmr - 16'd1;
        end
      end
      OFF: begin
        if (expired) begin
          if (is_machine) begin
            state_n = BLANK;
            load    = 1'b1;
            tmr_n   = 16'(BLANK_TICKS);
          end else begin
            state_n = IDLE;
          end
        end else if (tick) begin
          tmr_n = tmr - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmr         <= 16'd0;
      ton_q       <= 16'd0;
      toff_q      <= 16'd0;
      mask_q      <= 8'd0;
      pwm         <= 8'd0;
      pwm_q       <= 2'b00;
      pulse_start <= 1'b0;
      pulse_done  <= 1'b0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      if (load) begin
        ton_q  <= at_least_one(Ton_data);
        toff_q <= at_least_one(Toff_data);
        mask_q <= mask_n;
      end
      pwm         <= on_n ? mask_n : 8'h00;
      pwm_q       <= on_n ? 2'b11 : 2'b00;
      pulse_start <= load;
      pulse_done  <= (state_n == OFF) && (state != OFF);
    end
  end

  pulse_stat_cnt u_cnt (
    .clk        (sys_clk),
    .rst_n      (rst_n),
    .clr        (cnt_clr),
    .hit        (cls),
    .null_num   (null_pulse_num),
    .normal_num (normal_pulse_num),
    .short_num  (short_pulse_num)
  );

endmodule
